// File: rtl/space_wire_pkg.sv
// Shared SpaceWire character constants: control codes, character lengths,
// the NULL pattern used for alignment, N-Char marker encodings and RX states.
package space_wire_pkg;

  // Control codes; the first-arrived code bit is the LSB.
  localparam logic [1:0] CodeFct = 2'd0;
  localparam logic [1:0] CodeEop = 2'd1;
  localparam logic [1:0] CodeEep = 2'd2;
  localparam logic [1:0] CodeEsc = 2'd3;

  localparam int unsigned CtrlCharLen = 4;
  localparam int unsigned DataCharLen = 10;

  // ESC flag+code, FCT parity (0), FCT flag+code, oldest bit in the MSB.
  localparam logic [6:0] NullPattern = 7'b1110100;

  localparam logic [8:0] RxDataEop = 9'h100;
  localparam logic [8:0] RxDataEep = 9'h101;

  typedef enum logic [1:0] {
    StHunt    = 2'd0,
    StAligned = 2'd1,
    StError   = 2'd2
  } rx_state_e;

endpackage

// File: rtl/space_wire_rx_char_decoder.sv
// SpaceWire receive character decoder: aligns on the first NULL, then
// deserialises, parity-checks and classifies characters in the RX clock domain.
module space_wire_rx_char_decoder
  import space_wire_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx_enable,
  input  logic       i_rx_bit,
  input  logic       i_rx_bit_valid,
  output logic       o_got_null,
  output logic       o_got_fct,
  output logic       o_got_time_code,
  output logic [7:0] o_rx_time_code,
  output logic       o_rx_data_valid,
  output logic [8:0] o_rx_data,
  output logic       o_parity_error,
  output logic       o_escape_error
);

  localparam logic [3:0] CtrlLastIdx = 4'(CtrlCharLen - 1);
  localparam logic [3:0] DataLastIdx = 4'(DataCharLen - 1);

  rx_state_e  r_state;
  logic [7:0] r_shift;
  logic [3:0] r_bit_cnt;
  logic       r_is_ctrl;
  logic       r_parity_bit;
  logic       r_acc;
  logic       r_esc_pending;

  logic [6:0] w_window;
  logic       w_null_match;
  logic       w_parity_ok;
  logic       w_last;
  logic [1:0] w_code;
  logic [7:0] w_data;

  always_comb begin
    w_window     = {r_shift[5:0], i_rx_bit};
    w_null_match = (w_window == NullPattern);
    // Odd parity over previous character's code/data bits plus P and F.
    w_parity_ok  = r_acc ^ r_parity_bit ^ i_rx_bit;
    w_last       = (r_bit_cnt == (r_is_ctrl ? CtrlLastIdx : DataLastIdx));
    // Code/data bits are shifted in from the top, so the current bit completes them.
    w_code       = {i_rx_bit, r_shift[7]};
    w_data       = {i_rx_bit, r_shift[7:1]};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state         <= StHunt;
      r_shift         <= '0;
      r_bit_cnt       <= '0;
      r_is_ctrl       <= 1'b0;
      r_parity_bit    <= 1'b0;
      r_acc           <= 1'b0;
      r_esc_pending   <= 1'b0;
      o_got_null      <= 1'b0;
      o_got_fct       <= 1'b0;
      o_got_time_code <= 1'b0;
      o_rx_time_code  <= '0;
      o_rx_data_valid <= 1'b0;
      o_rx_data       <= '0;
      o_parity_error  <= 1'b0;
      o_escape_error  <= 1'b0;
    end else begin
      o_got_null      <= 1'b0;
      o_got_fct       <= 1'b0;
      o_got_time_code <= 1'b0;
      o_rx_data_valid <= 1'b0;
      if (!i_rx_enable) begin
        r_state        <= StHunt;
        r_shift        <= '0;
        r_bit_cnt      <= '0;
        r_is_ctrl      <= 1'b0;
        r_parity_bit   <= 1'b0;
        r_acc          <= 1'b0;
        r_esc_pending  <= 1'b0;
        o_rx_time_code <= '0;
        o_rx_data      <= '0;
        o_parity_error <= 1'b0;
        o_escape_error <= 1'b0;
      end else if (i_rx_bit_valid) begin
        case (r_state)
          StHunt: begin
            r_shift <= {r_shift[6:0], i_rx_bit};
            if (w_null_match) begin
              o_got_null    <= 1'b1;
              r_shift       <= '0;
              r_bit_cnt     <= '0;
              r_acc         <= 1'b0;
              r_esc_pending <= 1'b0;
              r_state       <= StAligned;
            end
          end

          StAligned: begin
            if (r_bit_cnt == 4'd0) begin
              r_parity_bit <= i_rx_bit;
              r_bit_cnt    <= 4'd1;
            end else if (r_bit_cnt == 4'd1) begin
              if (!w_parity_ok) begin
                o_parity_error <= 1'b1;
                r_state        <= StError;
              end else begin
                r_is_ctrl <= i_rx_bit;
                r_acc     <= 1'b0;
                r_bit_cnt <= 4'd2;
              end
            end else begin
              r_shift <= {i_rx_bit, r_shift[7:1]};
              r_acc   <= r_acc ^ i_rx_bit;
              if (!w_last) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end else begin
                r_bit_cnt <= '0;
                if (r_is_ctrl) begin
                  unique case (w_code)
                    CodeEsc: begin
                      if (r_esc_pending) begin
                        o_escape_error <= 1'b1;
                        r_state        <= StError;
                      end else begin
                        r_esc_pending <= 1'b1;
                      end
                    end
                    CodeFct: begin
                      if (r_esc_pending) begin
                        o_got_null    <= 1'b1;
                        r_esc_pending <= 1'b0;
                      end else begin
                        o_got_fct <= 1'b1;
                      end
                    end
                    CodeEop, CodeEep: begin
                      if (r_esc_pending) begin
                        o_escape_error <= 1'b1;
                        r_state        <= StError;
                      end else begin
                        o_rx_data_valid <= 1'b1;
                        o_rx_data       <= (w_code == CodeEop) ? RxDataEop : RxDataEep;
                      end
                    end
                  endcase
                end else if (r_esc_pending) begin
                  o_got_time_code <= 1'b1;
                  o_rx_time_code  <= w_data;
                  r_esc_pending   <= 1'b0;
                end else begin
                  o_rx_data_valid <= 1'b1;
                  o_rx_data       <= {1'b0, w_data};
                end
              end
            end
          end

          StError: begin
            // Held until the link state machine drops i_rx_enable.
          end

          default: r_state <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_space_wire_rx_char_decoder.sv
// Directed bench for the SpaceWire RX character decoder: encodes characters
// with correct or corrupted parity and checks pulse counts and held outputs.
module tb_space_wire_rx_char_decoder;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_rx_enable;
  logic       i_rx_bit;
  logic       i_rx_bit_valid;
  logic       o_got_null;
  logic       o_got_fct;
  logic       o_got_time_code;
  logic [7:0] o_rx_time_code;
  logic       o_rx_data_valid;
  logic [8:0] o_rx_data;
  logic       o_parity_error;
  logic       o_escape_error;

  space_wire_rx_char_decoder u_dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_rx_enable     (i_rx_enable),
    .i_rx_bit        (i_rx_bit),
    .i_rx_bit_valid  (i_rx_bit_valid),
    .o_got_null      (o_got_null),
    .o_got_fct       (o_got_fct),
    .o_got_time_code (o_got_time_code),
    .o_rx_time_code  (o_rx_time_code),
    .o_rx_data_valid (o_rx_data_valid),
    .o_rx_data       (o_rx_data),
    .o_parity_error  (o_parity_error),
    .o_escape_error  (o_escape_error)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_null = 0;
  int cnt_fct = 0;
  int cnt_tc = 0;
  int cnt_dv = 0;
  int cnt_multi = 0;
  logic [8:0] last_data = '0;
  logic tb_acc;

  // Pulses last one full cycle, so the falling edge sees each exactly once.
  always @(negedge i_clk) begin
    if (o_got_null) cnt_null++;
    if (o_got_fct) cnt_fct++;
    if (o_got_time_code) cnt_tc++;
    if (o_rx_data_valid) begin
      cnt_dv++;
      last_data = o_rx_data;
    end
    if (32'(o_got_null) + 32'(o_got_fct) + 32'(o_got_time_code) + 32'(o_rx_data_valid) > 1)
      cnt_multi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge i_clk);
    i_rx_bit       = b;
    i_rx_bit_valid = 1'b1;
    @(negedge i_clk);
    i_rx_bit_valid = 1'b0;
  endtask

  task automatic send_ctrl(input logic [1:0] code, input logic bad);
    send_bit(tb_acc ^ bad);
    send_bit(1'b1);
    send_bit(code[0]);
    send_bit(code[1]);
    tb_acc = code[0] ^ code[1];
    idle(2);
  endtask

  task automatic send_data(input logic [7:0] d, input logic bad);
    send_bit(~tb_acc ^ bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    tb_acc = ^d;
    idle(2);
  endtask

  task automatic send_null();
    send_ctrl(2'd3, 1'b0);
    send_ctrl(2'd0, 1'b0);
  endtask

  task automatic toggle_enable();
    @(negedge i_clk);
    i_rx_enable = 1'b0;
    idle(2);
    i_rx_enable = 1'b1;
    tb_acc      = 1'b0;
    idle(1);
  endtask

  int base_tc;
  int base_dv;
  int base_null;

  initial begin
    i_reset_n      = 1'b0;
    i_rx_enable    = 1'b0;
    i_rx_bit       = 1'b0;
    i_rx_bit_valid = 1'b0;
    tb_acc         = 1'b0;
    idle(3);
    check_eq("reset_null", 32'(o_got_null), 32'd0);
    check_eq("reset_tc", 32'(o_rx_time_code), 32'd0);
    check_eq("reset_data", 32'(o_rx_data), 32'd0);
    check_eq("reset_perr", 32'(o_parity_error), 32'd0);
    check_eq("reset_eerr", 32'(o_escape_error), 32'd0);
    i_reset_n = 1'b1;
    idle(1);
    i_rx_enable = 1'b1;
    idle(1);

    // Alignment after leading junk bits, then a second NULL in ALIGNED.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_null();
    check_eq("align_null", 32'(cnt_null), 32'd1);
    send_null();
    check_eq("second_null", 32'(cnt_null), 32'd2);
    check_eq("no_fct_yet", 32'(cnt_fct), 32'd0);

    send_ctrl(2'd3, 1'b0);
    send_data(8'h85, 1'b0);
    check_eq("tc_pulse", 32'(cnt_tc), 32'd1);
    check_eq("tc_value", 32'(o_rx_time_code), 32'h85);
    check_eq("tc_no_data", 32'(cnt_dv), 32'd0);

    send_data(8'h3C, 1'b0);
    check_eq("data_pulse", 32'(cnt_dv), 32'd1);
    check_eq("data_value", 32'(last_data), 32'h03C);
    send_ctrl(2'd1, 1'b0);
    check_eq("eop_pulse", 32'(cnt_dv), 32'd2);
    check_eq("eop_value", 32'(last_data), 32'h100);
    send_ctrl(2'd0, 1'b0);
    check_eq("fct_pulse", 32'(cnt_fct), 32'd1);
    send_ctrl(2'd2, 1'b0);
    check_eq("eep_value", 32'(o_rx_data), 32'h101);
    check_eq("tc_held", 32'(o_rx_time_code), 32'h85);

    // Parity error: sticky, suppresses the character and later NULLs.
    base_null = cnt_null;
    send_data(8'h55, 1'b1);
    check_eq("perr_set", 32'(o_parity_error), 32'd1);
    check_eq("perr_no_data", 32'(cnt_dv), 32'd3);
    check_eq("perr_no_eerr", 32'(o_escape_error), 32'd0);
    tb_acc = 1'b0;
    send_null();
    check_eq("perr_ignores_null", 32'(cnt_null), 32'(base_null));
    toggle_enable();
    check_eq("perr_cleared", 32'(o_parity_error), 32'd0);

    // ESC followed by ESC, then ESC followed by EEP.
    send_null();
    check_eq("realign_null", 32'(cnt_null), 32'(base_null + 1));
    send_ctrl(2'd3, 1'b0);
    send_ctrl(2'd3, 1'b0);
    check_eq("esc_esc_err", 32'(o_escape_error), 32'd1);
    check_eq("esc_esc_no_perr", 32'(o_parity_error), 32'd0);
    toggle_enable();
    check_eq("eerr_cleared", 32'(o_escape_error), 32'd0);
    base_dv = cnt_dv;
    send_null();
    send_ctrl(2'd3, 1'b0);
    send_ctrl(2'd2, 1'b0);
    check_eq("esc_eep_err", 32'(o_escape_error), 32'd1);
    check_eq("esc_eep_no_data", 32'(cnt_dv), 32'(base_dv));
    toggle_enable();

    // Enable drop mid-character clears held outputs and forces a new hunt.
    send_null();
    send_ctrl(2'd3, 1'b0);
    send_data(8'h85, 1'b0);
    check_eq("tc_before_drop", 32'(o_rx_time_code), 32'h85);
    send_bit(~tb_acc);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    toggle_enable();
    check_eq("drop_clears_tc", 32'(o_rx_time_code), 32'd0);
    base_tc = cnt_tc;
    base_dv = cnt_dv;
    send_ctrl(2'd3, 1'b0);
    send_data(8'h01, 1'b0);
    check_eq("unaligned_no_tc", 32'(cnt_tc), 32'(base_tc));
    check_eq("unaligned_no_data", 32'(cnt_dv), 32'(base_dv));
    check_eq("unaligned_tc_zero", 32'(o_rx_time_code), 32'd0);
    // ESC+0x01 itself contains the NULL bit pattern, so restart the hunt cleanly.
    toggle_enable();
    send_null();
    send_ctrl(2'd3, 1'b0);
    send_data(8'h01, 1'b0);
    check_eq("aligned_tc", 32'(cnt_tc), 32'(base_tc + 1));
    check_eq("aligned_tc_value", 32'(o_rx_time_code), 32'h01);
    check_eq("aligned_tc_no_data", 32'(cnt_dv), 32'(base_dv));

    check_eq("one_pulse_per_cycle", 32'(cnt_multi), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/space_wire_rx_char_decoder.md
# space_wire_rx_char_decoder

Receive-side character decoder for the SpaceWire link, running in the recovered receive-clock domain. It takes the serial bit stream from the data/strobe recovery stage and first aligns to the first NULL. It then deserialises and parity-checks every character and classifies it as NULL, FCT, EOP, EEP, N-Char data or time-code. It produces `o_got_time_code` / `o_rx_time_code`, which feed the system-clock time-code controller through its one-pulse synchroniser.

## Interface
- No parameters. Character lengths and control codes are constants in `space_wire_pkg`.
- `i_clk` in 1: clock (receive clock domain).
- `i_reset_n` in 1: reset, asynchronous, active-low.
- `i_rx_enable` in 1: low forces HUNT synchronously and suppresses all outputs; high allows decoding.
- `i_rx_bit` in 1: recovered serial bit, in arrival order.
- `i_rx_bit_valid` in 1: qualifies `i_rx_bit` for one cycle.
- `o_got_null` out 1: 1-cycle pulse per NULL (ESC+FCT), including the aligning NULL.
- `o_got_fct` out 1: 1-cycle pulse per standalone FCT.
- `o_got_time_code` out 1: 1-cycle pulse per time-code (ESC+data char).
- `o_rx_time_code` out 8: last time-code; [7:6] control flags, [5:0] time. Held between time-codes.
- `o_rx_data_valid` out 1: 1-cycle pulse per N-Char.
- `o_rx_data` out 9: bit8 = 0 means data byte; bit8 = 1 with 0x00 means EOP, 0x01 means EEP. Held.
- `o_parity_error` out 1: sticky until HUNT is re-entered.
- `o_escape_error` out 1: sticky until HUNT is re-entered.

## Operation
- States: HUNT → ALIGNED → ERROR.
- **Reset / `i_rx_enable` low**
  - State goes to HUNT.
  - All outputs, shift register, bit counter, escape flag and parity accumulator go to 0.
- **HUNT**
  - A 7-bit window shifts on each valid bit.
  - On match with arrival sequence 1,1,1,0,1,0,0 (ESC flag+code, FCT parity = 0, flag, code):
    - pulse `o_got_null`;
    - load parity accumulator with 0 (XOR of FCT code bits);
    - go to ALIGNED, where the next bit is a parity bit.
- **ALIGNED**
  - Bit 0 is P and bit 1 is the flag F.
  - F = 1 means a control character: 2 code bits, 4 bits total.
  - F = 0 means a data character: 8 data bits LSB-first, 10 bits total.
  - Parity check at bit 1: `acc ^ P ^ F` must equal 1, where `acc` is the XOR of the previous character's code/data bits.
  - On failure: `o_parity_error` ← 1, go to ERROR, and decode nothing from that character.
  - Control codes (first-arrived bit is LSB): FCT = 0, EOP = 1, EEP = 2, ESC = 3.
  - On character completion:
    - ESC with no ESC pending: set pending, no output.
    - FCT with ESC pending: NULL; clear pending.
    - FCT with no ESC pending: `o_got_fct`.
    - Data with ESC pending: time-code; update `o_rx_time_code`; clear pending.
    - Data with no ESC pending: N-Char data.
    - EOP/EEP with no ESC pending: N-Char marker.
    - ESC pending followed by ESC, EOP or EEP: `o_escape_error` ← 1, go to ERROR.
  - `acc` is recomputed from the completed character's code/data bits.
- **ERROR**
  - Ignores bits and generates no pulses.
  - Errors are held until `i_rx_enable` falls; the link state machine owns recovery.

## Timing
- All pulses and held outputs are registered and appear the cycle after the `i_rx_bit_valid` cycle carrying the character's last bit.
- `o_rx_time_code` changes only in the same cycle as `o_got_time_code` rises. It then stays stable at least until the next time-code, because the system-domain consumer samples it after synchroniser latency.
- Bit-valid gaps of any length are tolerated; the bit counter advances only on valid bits.
- `i_rx_enable` falling mid-character discards the partial character. The next enable requires a fresh NULL alignment.
- Parity failure and escape error on the same character: parity error wins; `o_escape_error` stays 0.
- Minimum spacing is 4 valid bits between pulses, so at most one pulse output is high per cycle.

## Structure
- `space_wire_pkg` holds:
  - control-code constants (FCT, EOP, EEP, ESC);
  - lengths 4 and 10;
  - the HUNT NULL pattern;
  - the EOP/EEP `o_rx_data` encodings;
  - the state enum.
- Single module, no sub-module. The clock-domain crossing belongs downstream (`space_wire_sync_one_pulse`).

## Test plan
- NULL after 3 random leading bits → `o_got_null` once, state ALIGNED; a second NULL → second pulse.
- ESC + data 0x85 with correct parity → `o_got_time_code` pulse, `o_rx_time_code` = 0x85; `o_rx_data_valid` stays 0.
- Data 0x3C, then EOP, then FCT → `o_rx_data` = 0x03C (valid), then 0x100 (valid), then `o_got_fct` pulse.
- Flip a parity bit on a data character → `o_parity_error` = 1, no data pulse, further valid NULLs ignored until `i_rx_enable` toggles.
- ESC, ESC → `o_escape_error` = 1; ESC + EEP → same.
- Drop `i_rx_enable` after 5 bits of a data character, re-enable, send time-code 0x01 without a NULL → no output; send NULL then 0x01 → time-code 0x01 reported.
